// File: rtl/reader_pie_tx.sv
// Purpose: reader-side Gen2 PIE transmitter (delimiter, data-0, RTcal, optional TRcal, data bits).
// Latency: o_pie goes low the cycle after an accepted i_start; all outputs are registered.
// Backpressure: one-bit buffer fed by valid/ready; an empty buffer at a data symbol boundary aborts the frame.
module reader_pie_tx #(
    parameter int TARI  = 16,
    parameter int DATA1 = 28,
    parameter int PW    = 8,
    parameter int DELIM = 20,
    parameter int TRCAL = 64,
    parameter int CNT_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_preamble,
    input  logic [7:0] i_len,
    input  logic       i_bit_valid,
    input  logic       i_bit,
    output logic       o_bit_ready,
    output logic       o_pie,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELIM,
        S_D0,
        S_RTCAL,
        S_TRCAL,
        S_BITS
    } state_t;

    localparam logic [CNT_W-1:0] LEN_DELIM = CNT_W'(DELIM);
    localparam logic [CNT_W-1:0] LEN_D0    = CNT_W'(TARI);
    localparam logic [CNT_W-1:0] LEN_D1    = CNT_W'(DATA1);
    localparam logic [CNT_W-1:0] LEN_RTCAL = CNT_W'(TARI + DATA1);
    localparam logic [CNT_W-1:0] LEN_TRCAL = CNT_W'(TRCAL);
    localparam logic [CNT_W-1:0] LEN_PW    = CNT_W'(PW);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       sent_q, sent_d;
    logic [7:0]       fetched_q, fetched_d;
    logic             pre_q, pre_d;
    logic             buf_full_q, buf_full_d;
    logic             buf_q, buf_d;
    logic             pie_q, pie_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             under_q, under_d;
    logic             rdy_q, rdy_d;

    logic             xfer;
    logic             avail;
    logic             nxt_bit;
    logic             enter_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            sent_q     <= '0;
            fetched_q  <= '0;
            pre_q      <= 1'b0;
            buf_full_q <= 1'b0;
            buf_q      <= 1'b0;
            pie_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            under_q    <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sent_q     <= sent_d;
            fetched_q  <= fetched_d;
            pre_q      <= pre_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            pie_q      <= pie_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            under_q    <= under_d;
            rdy_q      <= rdy_d;
        end
    end

    // A bit accepted on a symbol-boundary edge is forwarded straight into that symbol.
    assign xfer    = i_bit_valid & rdy_q;
    assign avail   = buf_full_q | xfer;
    assign nxt_bit = buf_full_q ? buf_q : i_bit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sent_d     = sent_q;
        fetched_d  = fetched_q;
        pre_d      = pre_q;
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        under_d    = 1'b0;
        enter_bits = 1'b0;

        if (xfer) begin
            buf_full_d = 1'b1;
            buf_d      = i_bit;
            fetched_d  = fetched_q + 8'd1;
        end

        if (state_q == S_IDLE) begin
            // The done cycle is a dead cycle for i_start.
            if (i_start && !done_q) begin
                state_d    = S_DELIM;
                cnt_d      = LEN_DELIM;
                len_d      = i_len;
                pre_d      = i_preamble;
                sent_d     = '0;
                fetched_d  = '0;
                buf_full_d = 1'b0;
                busy_d     = 1'b1;
            end
        end else if (cnt_q != CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            unique case (state_q)
                S_DELIM: begin
                    state_d = S_D0;
                    cnt_d   = LEN_D0;
                end
                S_D0: begin
                    state_d = S_RTCAL;
                    cnt_d   = LEN_RTCAL;
                end
                S_RTCAL: begin
                    if (pre_q) begin
                        state_d = S_TRCAL;
                        cnt_d   = LEN_TRCAL;
                    end else begin
                        enter_bits = 1'b1;
                    end
                end
                default: enter_bits = 1'b1;
            endcase
        end

        if (enter_bits) begin
            if (sent_q == len_q) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else if (avail) begin
                state_d    = S_BITS;
                cnt_d      = nxt_bit ? LEN_D1 : LEN_D0;
                sent_d     = sent_q + 8'd1;
                buf_full_d = 1'b0;
            end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                under_d = 1'b1;
            end
        end

        // Symbols count down L..1; the last PW counts are the low pulse.
        if (state_d == S_IDLE) begin
            pie_d = 1'b1;
        end else if (state_d == S_DELIM) begin
            pie_d = 1'b0;
        end else begin
            pie_d = (cnt_d > LEN_PW);
        end

        rdy_d = busy_d & ~buf_full_d & (fetched_d < len_d);
    end

    assign o_bit_ready = rdy_q;
    assign o_pie       = pie_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_underrun  = under_q;

endmodule

// File: tb/tb_reader_pie_tx.sv
// Directed bench for reader_pie_tx: frames are captured cycle by cycle and compared as
// high/low run lengths against hand-built symbol lists.
module tb_reader_pie_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       i_preamble;
    logic [7:0] i_len;
    logic       i_bit_valid;
    logic       i_bit;
    logic       o_bit_ready;
    logic       o_pie;
    logic       o_busy;
    logic       o_done;
    logic       o_underrun;

    reader_pie_tx dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_preamble  (i_preamble),
        .i_len       (i_len),
        .i_bit_valid (i_bit_valid),
        .i_bit       (i_bit),
        .o_bit_ready (o_bit_ready),
        .o_pie       (o_pie),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_underrun  (o_underrun)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;

    logic tx_bits [256];
    logic pie_log [$];
    int   exp_val [$];
    int   exp_len [$];
    int   end_cycle;
    int   acc;
    int   ready_cycles;
    int   busy_gaps;
    int   extra;
    logic got_done;
    logic got_underrun;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int v, input int l);
        exp_val.push_back(v);
        exp_len.push_back(l);
    endtask

    task automatic push_sym(input int l);
        push_run(1, l - 8);
        push_run(0, 8);
    endtask

    task automatic push_header(input logic pre);
        exp_val.delete();
        exp_len.delete();
        push_run(0, 20);
        push_sym(16);
        push_sym(44);
        if (pre) push_sym(64);
    endtask

    function automatic int run_mismatch();
        int rv [$];
        int rl [$];
        int m;
        int n;
        foreach (pie_log[i]) begin
            if (rv.size() == 0 || rv[rv.size()-1] != int'(pie_log[i])) begin
                rv.push_back(int'(pie_log[i]));
                rl.push_back(1);
            end else begin
                rl[rl.size()-1] = rl[rl.size()-1] + 1;
            end
        end
        n = (rv.size() < exp_val.size()) ? rv.size() : exp_val.size();
        m = (rv.size() > exp_val.size()) ? rv.size() - exp_val.size() : exp_val.size() - rv.size();
        for (int i = 0; i < n; i++) begin
            if (rv[i] != exp_val[i] || rl[i] != exp_len[i]) m++;
        end
        return m;
    endfunction

    // Starts a frame, then logs o_pie per cycle until o_done/o_underrun or the cycle budget expires.
    task automatic run_frame(input logic pre, input int len, input int valid_limit,
                             input int start_at, input int max_cycles);
        logic will;
        pie_log.delete();
        acc          = 0;
        ready_cycles = 0;
        busy_gaps    = 0;
        got_done     = 1'b0;
        got_underrun = 1'b0;
        end_cycle    = -1;
        i_preamble   = pre;
        i_len        = len[7:0];
        i_start      = 1'b1;
        step();
        i_start      = 1'b0;
        i_preamble   = 1'b0;
        i_len        = 8'd0;
        for (int c = 1; c <= max_cycles; c++) begin
            if (o_done || o_underrun) begin
                got_done     = o_done;
                got_underrun = o_underrun;
                end_cycle    = c;
                break;
            end
            pie_log.push_back(o_pie);
            if (o_bit_ready) ready_cycles++;
            if (!o_busy) busy_gaps++;
            i_bit_valid = (acc < valid_limit);
            i_bit       = (acc < 256) ? tx_bits[acc] : 1'b0;
            i_start     = (c == start_at);
            will        = i_bit_valid && o_bit_ready;
            step();
            if (will) acc++;
            i_start = 1'b0;
        end
        i_bit_valid = 1'b0;
        i_bit       = 1'b0;
    endtask

    task automatic count_events(input int n);
        extra = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (o_done || o_underrun || o_bit_ready || o_busy || !o_pie) extra++;
        end
    endtask

    initial begin
        int sum;
        rst         = 1'b1;
        i_start     = 1'b0;
        i_preamble  = 1'b0;
        i_len       = 8'd0;
        i_bit_valid = 1'b0;
        i_bit       = 1'b0;
        foreach (tx_bits[i]) tx_bits[i] = 1'b0;
        step();
        step();
        check("rst_pie", o_pie, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_underrun", o_underrun, 0);
        check("rst_ready", o_bit_ready, 0);
        rst = 1'b0;
        step();

        // Frame-sync, bits 1,0
        tx_bits[0] = 1'b1;
        tx_bits[1] = 1'b0;
        run_frame(1'b0, 2, 256, -1, 400);
        push_header(1'b0);
        push_sym(28);
        push_sym(16);
        check("fs_runs", run_mismatch(), 0);
        check("fs_end_cycle", end_cycle, 125);
        check("fs_done", got_done, 1);
        check("fs_underrun", got_underrun, 0);
        check("fs_accepted", acc, 2);
        check("fs_ready_cycles", ready_cycles, 2);
        check("fs_busy_gaps", busy_gaps, 0);
        check("fs_end_pie", o_pie, 1);
        check("fs_end_busy", o_busy, 0);
        step();

        // Preamble, len 0
        run_frame(1'b1, 0, 256, -1, 400);
        push_header(1'b1);
        check("pre_runs", run_mismatch(), 0);
        check("pre_end_cycle", end_cycle, 145);
        check("pre_done", got_done, 1);
        check("pre_ready_cycles", ready_cycles, 0);
        count_events(4);
        check("pre_after_events", extra, 0);

        // Underrun: only the first of three bits is offered
        tx_bits[0] = 1'b1;
        tx_bits[1] = 1'b1;
        tx_bits[2] = 1'b0;
        run_frame(1'b0, 3, 1, -1, 400);
        push_header(1'b0);
        push_sym(28);
        check("ur_runs", run_mismatch(), 0);
        check("ur_end_cycle", end_cycle, 109);
        check("ur_underrun", got_underrun, 1);
        check("ur_done", got_done, 0);
        check("ur_accepted", acc, 1);
        check("ur_end_pie", o_pie, 1);
        check("ur_end_busy", o_busy, 0);
        i_bit_valid = 1'b1;
        count_events(5);
        i_bit_valid = 1'b0;
        check("ur_after_events", extra, 0);

        // Start pulsed during BITS and in the done cycle, then restart
        tx_bits[0] = 1'b0;
        tx_bits[1] = 1'b1;
        run_frame(1'b0, 2, 256, 90, 400);
        push_header(1'b0);
        push_sym(16);
        push_sym(28);
        check("ign_runs", run_mismatch(), 0);
        check("ign_end_cycle", end_cycle, 125);
        check("ign_done", got_done, 1);
        i_start = 1'b1;
        step();
        check("ign_done_cycle_busy", o_busy, 0);
        check("ign_done_cycle_pie", o_pie, 1);
        tx_bits[0] = 1'b1;
        run_frame(1'b0, 1, 256, -1, 400);
        push_header(1'b0);
        push_sym(28);
        check("restart_runs", run_mismatch(), 0);
        check("restart_end_cycle", end_cycle, 109);
        check("restart_done", got_done, 1);
        step();

        // Reset in the TRcal low pulse
        i_preamble = 1'b1;
        i_len      = 8'd0;
        i_start    = 1'b1;
        step();
        i_start    = 1'b0;
        i_preamble = 1'b0;
        repeat (139) step();
        check("trcal_low_before_rst", o_pie, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_pie", o_pie, 1);
        check("midrst_busy", o_busy, 0);
        check("midrst_done", o_done, 0);
        check("midrst_underrun", o_underrun, 0);
        count_events(3);
        check("midrst_after_events", extra, 0);
        tx_bits[0] = 1'b1;
        tx_bits[1] = 1'b0;
        run_frame(1'b0, 2, 256, -1, 400);
        push_header(1'b0);
        push_sym(28);
        push_sym(16);
        check("postrst_runs", run_mismatch(), 0);
        check("postrst_end_cycle", end_cycle, 125);
        check("postrst_done", got_done, 1);
        step();

        // 255 random bits, valid held high
        push_header(1'b0);
        sum = 0;
        for (int i = 0; i < 255; i++) begin
            tx_bits[i] = 1'($urandom_range(0, 1));
            push_sym(tx_bits[i] ? 28 : 16);
            sum += tx_bits[i] ? 28 : 16;
        end
        run_frame(1'b0, 255, 256, -1, 20000);
        check("long_runs", run_mismatch(), 0);
        check("long_end_cycle", end_cycle, 80 + sum + 1);
        check("long_done", got_done, 1);
        check("long_underrun", got_underrun, 0);
        check("long_accepted", acc, 255);
        check("long_busy_gaps", busy_gaps, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
